// File: rtl/dimension_swap_mux.sv
// Wide-word N:1 selector: transposes the entry array to per-bit vectors, muxes each bit
// through a 16:1 slice (2x mux8x1 + mux2x1) and registers the result. Optional: DIMSWAP_RANGE_ERR_EN.

module mux8x1 (
    input  logic [7:0] in,
    input  logic [2:0] port,
    output logic       out
);
    assign out = in[port];
endmodule

module mux2x1 (
    input  logic [1:0] in,
    input  logic       port,
    output logic       out
);
    assign out = in[port];
endmodule

module dimension_swap_mux #(
    parameter int INPUT_UNPACKED_SIZE = 16,
    parameter int INPUT_PACKED_SIZE   = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [INPUT_PACKED_SIZE-1:0]   in [INPUT_UNPACKED_SIZE],
    input  logic [3:0]                     port,
    input  logic                           in_valid,
    output logic [INPUT_UNPACKED_SIZE-1:0] swap_out [INPUT_PACKED_SIZE],
`ifdef DIMSWAP_RANGE_ERR_EN
    output logic                           range_err,
`endif
    output logic [INPUT_PACKED_SIZE-1:0]   out,
    output logic                           out_valid
);
    localparam int N    = INPUT_UNPACKED_SIZE;
    localparam int SIZE = INPUT_PACKED_SIZE;

    logic [SIZE-1:0] sel;
    logic [SIZE-1:0] out_q, out_d;
    logic            out_valid_q;

    for (genvar b = 0; b < SIZE; b++) begin : g_bit
        for (genvar e = 0; e < N; e++) begin : g_ent
            assign swap_out[b][e] = in[e][b];
        end

        // Entries beyond N are tied low so out-of-range selects return 0, never X.
        logic [15:0] vec;
        logic        lo, hi;
        always_comb begin
            vec        = '0;
            vec[N-1:0] = swap_out[b];
        end

        mux8x1 u_lo (.in(vec[7:0]),  .port(port[2:0]), .out(lo));
        mux8x1 u_hi (.in(vec[15:8]), .port(port[2:0]), .out(hi));
        mux2x1 u_2  (.in({hi, lo}),  .port(port[3]),   .out(sel[b]));
    end

    assign out_d = in_valid ? sel : out_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= in_valid;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

`ifdef DIMSWAP_RANGE_ERR_EN
    localparam logic [4:0] NUM = 5'(N);
    logic range_err_q, range_err_d;

    assign range_err_d = in_valid & ({1'b0, port} >= NUM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) range_err_q <= 1'b0;
        else          range_err_q <= range_err_d;
    end

    assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_dimension_swap_mux.sv
// Directed bench for dimension_swap_mux: three instances (16x4, 16x1, 10x8) on one clock/reset.

module tb_dimension_swap_mux;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 16 entries x 4 bits
    logic [3:0]  in4 [16];
    logic [3:0]  port4;
    logic        iv4;
    logic [15:0] sw4 [4];
    logic [3:0]  out4;
    logic        ov4;
    // 16 entries x 1 bit
    logic [0:0]  in1 [16];
    logic [3:0]  port1;
    logic        iv1;
    logic [15:0] sw1 [1];
    logic [0:0]  out1;
    logic        ov1;
    // 10 entries x 8 bits
    logic [7:0]  in8 [10];
    logic [3:0]  port8;
    logic        iv8;
    logic [9:0]  sw8 [8];
    logic [7:0]  out8;
    logic        ov8;
`ifdef DIMSWAP_RANGE_ERR_EN
    logic re4, re1, re8;
`endif

    dimension_swap_mux #(.INPUT_UNPACKED_SIZE(16), .INPUT_PACKED_SIZE(4)) u_dut4 (
        .clk(clk), .reset_n(rst_n), .in(in4), .port(port4), .in_valid(iv4),
        .swap_out(sw4),
`ifdef DIMSWAP_RANGE_ERR_EN
        .range_err(re4),
`endif
        .out(out4), .out_valid(ov4));

    dimension_swap_mux #(.INPUT_UNPACKED_SIZE(16), .INPUT_PACKED_SIZE(1)) u_dut1 (
        .clk(clk), .reset_n(rst_n), .in(in1), .port(port1), .in_valid(iv1),
        .swap_out(sw1),
`ifdef DIMSWAP_RANGE_ERR_EN
        .range_err(re1),
`endif
        .out(out1), .out_valid(ov1));

    dimension_swap_mux #(.INPUT_UNPACKED_SIZE(10), .INPUT_PACKED_SIZE(8)) u_dut8 (
        .clk(clk), .reset_n(rst_n), .in(in8), .port(port8), .in_valid(iv8),
        .swap_out(sw8),
`ifdef DIMSWAP_RANGE_ERR_EN
        .range_err(re8),
`endif
        .out(out8), .out_valid(ov8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] pats [5];

    initial begin
        pats[0] = 16'hA5C3; pats[1] = 16'h0000; pats[2] = 16'hFFFF;
        pats[3] = 16'h5A3C; pats[4] = 16'h8001;

        rst_n = 1'b0;
        port4 = '0; iv4 = 1'b0; port1 = '0; iv1 = 1'b0; port8 = '0; iv8 = 1'b0;
        for (int j = 0; j < 16; j++) begin in4[j] = 4'(j); in1[j] = 1'b0; end
        for (int j = 0; j < 10; j++) in8[j] = 8'h10 + 8'(j);

        // Clock runs during reset; outputs must stay cleared.
        #22;
        chk("rst_out4", 64'(out4), 64'h0);
        chk("rst_ov4",  64'(ov4),  64'h0);
        chk("rst_out8", 64'(out8), 64'h0);
        chk("rst_ov1",  64'(ov1),  64'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Sweep: in[j]=j, so out tracks port one edge later.
        for (int p = 0; p < 16; p++) begin
            port4 = 4'(p); iv4 = 1'b1;
            tick();
            chk($sformatf("sweep_out_p%0d", p), 64'(out4), 64'(p));
            chk($sformatf("sweep_ov_p%0d", p),  64'(ov4),  64'h1);
        end

        // Hold: capture F, then in_valid low while port wanders.
        port4 = 4'd15; iv4 = 1'b1;
        tick();
        chk("hold_cap", 64'(out4), 64'hF);
        iv4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            port4 = 4'(k + 1);
            tick();
            chk($sformatf("hold_out_%0d", k), 64'(out4), 64'hF);
            chk($sformatf("hold_ov_%0d", k),  64'(ov4),  64'h0);
        end

        // Transpose: only entry 3 nonzero (4'b1010) -> bits 1 and 3 show entry 3.
        for (int j = 0; j < 16; j++) in4[j] = 4'h0;
        in4[3] = 4'b1010;
        #1;
        chk("swap_b0", 64'(sw4[0]), 64'h0000);
        chk("swap_b1", 64'(sw4[1]), 64'h0008);
        chk("swap_b2", 64'(sw4[2]), 64'h0000);
        chk("swap_b3", 64'(sw4[3]), 64'h0008);

        // Reset between edges clears at once; swap_out is unaffected.
        for (int j = 0; j < 16; j++) in4[j] = 4'(j);
        port4 = 4'd7; iv4 = 1'b1;
        tick();
        chk("pre_rst_out", 64'(out4), 64'h7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", 64'(out4), 64'h0);
        chk("async_rst_ov",  64'(ov4),  64'h0);
        chk("rst_swap_b0",   64'(sw4[0]), 64'hAAAA);
        @(negedge clk);
        rst_n = 1'b1;
        port4 = 4'd2;
        tick();
        chk("post_rst_out", 64'(out4), 64'h2);
        chk("post_rst_ov",  64'(ov4),  64'h1);

        // SIZE=1: every port against a handful of 16-bit patterns.
        iv1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int e = 0; e < 16; e++) in1[e] = pats[i][e];
            for (int p = 0; p < 16; p++) begin
                port1 = 4'(p);
                tick();
                chk($sformatf("s1_%h_p%0d", pats[i], p), 64'(out1), 64'(pats[i][p]));
            end
        end
        for (int e = 0; e < 16; e++) in1[e] = pats[0][e];
        port1 = 4'd5;
        tick();
        chk("s1_spot_p5", 64'(out1), 64'h0);
        port1 = 4'd7;
        tick();
        chk("s1_spot_p7", 64'(out1), 64'h1);

        // N=10: out-of-range port yields 0, in-range returns the entry.
        port8 = 4'd12; iv8 = 1'b1;
        tick();
        chk("n10_p12_out", 64'(out8), 64'h00);
`ifdef DIMSWAP_RANGE_ERR_EN
        chk("n10_p12_re", 64'(re8), 64'h1);
`endif
        port8 = 4'd9;
        tick();
        chk("n10_p9_out", 64'(out8), 64'h19);
`ifdef DIMSWAP_RANGE_ERR_EN
        chk("n10_p9_re", 64'(re8), 64'h0);
`endif
        port8 = 4'd10;
        tick();
        chk("n10_p10_out", 64'(out8), 64'h00);
        port8 = 4'd0;
        tick();
        chk("n10_p0_out", 64'(out8), 64'h10);
        chk("n10_swap_b4", 64'(sw8[4]), 64'h3FF);
        chk("n10_swap_b0", 64'(sw8[0]), 64'h2AA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dimension_swap_mux.md
Name: dimension_swap_mux

Overview:
- Transposes an unpacked array of packed words into a packed-per-bit array, so the array is indexed as "one bit position across all entries".
- Uses the transposed view to drive SIZE identical 1-bit 16:1 mux slices. Each slice is two 8:1 base cells plus one 2:1 base cell.
- The selected word is registered.
- Used as the generic wide-word selector behind register-file read ports and forwarding selects.

Parameters:
- INPUT_UNPACKED_SIZE, 16, number of entries N; legal range 2..16.
- INPUT_PACKED_SIZE, 1, width of each entry in bits (SIZE); legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  N x SIZE (unpacked N of packed SIZE)  entry data.
- port  input  4  selected entry index.
- in_valid  input  1  capture enable for the output register.
- swap_out  output  SIZE x N (unpacked SIZE of packed N)  transposed view of in; combinational.
- out  output  SIZE  registered selected entry.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Transpose (combinational, zero latency): for every b in 0..SIZE-1 and e in 0..N-1, swap_out[b][e] = in[e][b].
- Mux slice b: the 16-bit vector is swap_out[b] zero-extended to 16 bits.
  - Lower 8:1 cell takes bits [7:0], selected by port[2:0].
  - Upper 8:1 cell takes bits [15:8], selected by port[2:0].
  - 2:1 cell picks the upper cell when port[3]=1, otherwise the lower cell.
- Net selected value: sel = in[port] when port < N; sel = 0 when port >= N.
- Base cells: mux8x1 returns in[port[2:0]]; mux2x1 returns in[port[3]]. Both are pure combinational gates.
- Register stage (latency 1):
  - On each rising clk with in_valid=1: out <= sel.
  - On each rising clk with in_valid=0: out holds its value.
  - Every rising clk: out_valid <= in_valid.
- Reset:
  - reset_n=0 immediately forces out=0 and out_valid=0, independent of clk.
  - Release is synchronous to the next rising clk; the first capture occurs at the first edge after release.
  - Reset asserted mid-operation discards any pending capture.
  - swap_out is unaffected by reset.
- Simultaneous events:
  - A change on port or in in the same cycle as the edge captures the value present before the edge (ordinary setup).
  - in_valid toggling every cycle is legal.
- No X propagation from unused mux inputs: padded entries are tied to 0.

Optional Feature:
- Macro DIMSWAP_RANGE_ERR_EN.
- Defined:
  - Adds output port range_err (1 bit), registered alongside out.
  - range_err <= in_valid & (port >= N); reset value 0.
- Undefined:
  - The range_err port does not exist.
  - Out-of-range selects silently return 0.

Test Plan:
- N=16, SIZE=4, in[j]=j, in_valid=1; sweep port 0..15 at one port per cycle -> out equals port one cycle later each time; out_valid=1.
- N=16, SIZE=4, in[3]=4'b1010, others 0 -> swap_out[1][3]=1, swap_out[3][3]=1, swap_out[0][3]=0, swap_out[2][3]=0; swap_out[b][e]=0 for e!=3.
- SIZE=1: exhaustively drive every 16-bit in value against every port value (2^20 combinations), stepping the clock -> out == in[port] after each edge. Spot check: in=16'hA5C3, port=5 -> out=0; port=7 -> out=1.
- N=10, SIZE=8, in[j]=8'h10+j, port=12, DIMSWAP_RANGE_ERR_EN defined -> out=8'h00, range_err=1; then port=9 -> out=8'h19, range_err=0.
- Capture out=4'hF, then in_valid=0 for 3 cycles while port changes -> out stays 4'hF; out_valid=0 after the first edge.
- With out=4'h7, assert reset_n=0 between clock edges -> out=0 and out_valid=0 before the next edge. Release reset_n, then port=2 -> out=2 after the first edge following release.
